// File: rtl/cpu_ad48_muldiv.sv
// Iterative unsigned multiply/divide unit: one shift-add or restoring-divide step
// per cycle over a shared {hi, lo} register pair, ITER steps per operation.
module cpu_ad48_muldiv #(
  parameter int W    = 48,
  parameter int ITER = 48
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  logic         dst_bank,
  input  logic [2:0]   dst_idx,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         wb_en,
  output logic         wb_bank,
  output logic [2:0]   wb_idx,
  output logic         div_by_zero
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [1:0]    op_q;
  logic [W-1:0]  b_q;
  logic          bank_q;
  logic [2:0]    idx_q;
  logic [CW-1:0] cnt;
  // hi = product high half / partial remainder, lo = multiplier / quotient
  logic [W-1:0]  hi, lo;

  logic [W-1:0]  nxt_hi, nxt_lo, fin_res;
  logic [W:0]    msum, shifted, diff;
  logic          bz;

  always_comb begin
    nxt_hi  = hi;
    nxt_lo  = lo;
    msum    = '0;
    shifted = '0;
    diff    = '0;
    if (!op_q[1]) begin
      msum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
      nxt_hi = msum[W:1];
      nxt_lo = {msum[0], lo[W-1:1]};
    end else begin
      shifted = {hi, lo[W-1]};
      diff    = shifted - {1'b0, b_q};
      // diff[W] is the borrow: set means the trial subtraction must be undone
      if (!diff[W]) begin
        nxt_hi = diff[W-1:0];
        nxt_lo = {lo[W-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[W-1:0];
        nxt_lo = {lo[W-2:0], 1'b0};
      end
    end
  end

  // With a zero divisor every trial subtract succeeds, so the quotient
  // naturally ends all ones and the remainder ends equal to the dividend.
  assign fin_res = op_q[0] ? nxt_hi : nxt_lo;
  assign bz      = op_q[1] && (b_q == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      wb_en       <= 1'b0;
      div_by_zero <= 1'b0;
      result      <= '0;
      wb_bank     <= 1'b0;
      wb_idx      <= '0;
      cnt         <= '0;
      op_q        <= '0;
      b_q         <= '0;
      bank_q      <= 1'b0;
      idx_q       <= '0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      wb_en       <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: if (start && !flush) begin
          op_q   <= op;
          b_q    <= src_b;
          bank_q <= dst_bank;
          idx_q  <= dst_idx;
          hi     <= '0;
          lo     <= src_a;
          cnt    <= '0;
          state  <= RUN;
          busy   <= 1'b1;
        end
        RUN: if (flush) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          hi  <= nxt_hi;
          lo  <= nxt_lo;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ITER - 1)) begin
            state       <= DONE;
            done        <= 1'b1;
            result      <= fin_res;
            wb_en       <= !(!bank_q && idx_q == 3'd0);
            wb_bank     <= bank_q;
            wb_idx      <= idx_q;
            div_by_zero <= bz;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_ad48_muldiv.md
CPU_AD48_MULDIV -- requirements
Module: cpu_ad48_muldiv

Interface
REQ-001 Parameter: W, default 48, operand/result width.
REQ-002 Parameter: ITER, default 48, datapath iterations per operation; equals W.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  issue request; sampled only in IDLE.
REQ-006 op  in  2  00 MUL (low W bits), 01 MULHU (high W bits, unsigned), 10 DIVU, 11 REMU.
REQ-007 src_a  in  W  multiplicand / dividend.
REQ-008 src_b  in  W  multiplier / divisor.
REQ-009 dst_bank  in  1  destination bank; 1 = D, 0 = A.
REQ-010 dst_idx  in  3  destination register index.
REQ-011 flush  in  1  abort any in-flight operation.
REQ-012 busy  out  1  unit occupied; pipeline stalls new muldiv issue while high.
REQ-013 done  out  1  one-cycle result-valid pulse.
REQ-014 result  out  W  final result; valid when done=1.
REQ-015 wb_en  out  1  register-file write enable = done AND NOT (dst_bank=0 AND dst_idx=0).
REQ-016 wb_bank  out  1  latched dst_bank.
REQ-017 wb_idx  out  3  latched dst_idx.
REQ-018 div_by_zero  out  1  with done: DIVU/REMU had src_b=0; else 0.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-020 IDLE: start=1 and flush=0 at edge T latches op, src_a, src_b, dst_bank, dst_idx, clears counter, enters RUN at T+1.
REQ-021 RUN SHALL perform one iteration per cycle for exactly ITER cycles (T+1..T+ITER), then enter DONE.
REQ-022 MUL/MULHU: shift-add over an unsigned 2W-bit product; MUL returns bits [W-1:0], MULHU bits [2W-1:W].
REQ-023 DIVU/REMU: restoring division, one quotient bit per cycle, unsigned; DIVU returns quotient, REMU remainder.
REQ-024 Divide by zero: same latency; DIVU result = all ones, REMU result = src_a, div_by_zero=1.
REQ-025 DONE lasts exactly one cycle (T+ITER+1): done=1, result/wb_bank/wb_idx valid, wb_en per REQ-015; then IDLE.
REQ-026 busy=1 in RUN and DONE, 0 in IDLE; issue-to-done latency is ITER+1 cycles.
REQ-027 start in RUN or DONE SHALL be ignored: no queuing, latched operands unchanged.
REQ-028 flush in RUN or DONE: next state IDLE; no done/wb_en pulse for that operation; flush outranks start in the same cycle.
REQ-029 result, wb_bank, wb_idx SHALL hold their last values outside DONE; div_by_zero SHALL be 0 outside DONE.
REQ-030 Arithmetic SHALL wrap modulo 2^W; no overflow flag.

Reset
REQ-031 resetn=0 at an edge: state IDLE; busy, done, wb_en, div_by_zero = 0; result = 0; wb_bank = 0; wb_idx = 0; counter = 0.
REQ-032 Reset during RUN or DONE SHALL abort with no done pulse; start is ignored while resetn=0.
REQ-033 First start is accepted at the first edge where resetn=1.

Verification
REQ-034 MUL 7*5, dst D2, start at T -> busy at T+1..T+49; done/wb_en=1 only at T+49; result=0x000000000023; wb_bank=1; wb_idx=2.
REQ-035 MULHU 0xFFFFFFFFFFFF*2 -> result=0x000000000001; MUL with the same operands -> result=0xFFFFFFFFFFFE.
REQ-036 DIVU 17/5 -> result=3; REMU 17/5 -> result=2; div_by_zero=0 for both.
REQ-037 DIVU 123/0 -> result=0xFFFFFFFFFFFF, div_by_zero=1; REMU 123/0 -> result=0x00000000007B, div_by_zero=1.
REQ-038 MUL 3*4, dst A0 -> done=1, wb_en=0, result=0x00000000000C.
REQ-039 Start MUL at T; second start at T+5 (ignored); flush at T+10 -> busy=0 at T+11, no done; new DIVU 100/7 at T+12 -> done at T+61, result=14; resetn=0 mid-RUN -> busy=0, done never pulses.
